// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and the data RAM, with load forwarding and a flush handshake.
// Optional store coalescing into the youngest entry is enabled by defining SB_COALESCE_EN.

module sb_entry #(
    parameter int WA_W   = 30,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              we,
    input  logic [WA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [WA_W-1:0]   cmp_addr,
    output logic [WA_W-1:0]   addr,
    output logic [DATA_W-1:0] data,
    output logic              match
);
    // Payload is never reset; validity is tracked by the head pointer and count.
    always_ff @(posedge clka) begin
        if (we) begin
            addr <= waddr;
            data <= wdata;
        end
    end

    assign match = (addr == cmp_addr);
endmodule

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clka,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {FL_IDLE, FL_DRAIN, FL_WAIT} fl_state_t;

    logic [PTR_W-1:0]              head, tail, young;
    logic [CNT_W-1:0]              count;
    logic                          ready_q;
    fl_state_t                     fl_state, fl_next;
    logic                          pop, coal, accept, alloc, merge;
    logic [DEPTH-1:0]              ent_we, ent_match;
    logic [DEPTH-1:0][WA_W-1:0]    ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data;
    logic                          unused_lsbs;

    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign young = tail - PTR_W'(1);
    assign pop   = mem_we && mem_ack;

`ifdef SB_COALESCE_EN
    // Merge into the youngest entry unless that entry is the head leaving this cycle.
    assign coal = st_valid && (count != '0) &&
                  (ent_addr[young] == st_addr[ADDR_W-1:2]) &&
                  !((count == CNT_W'(1)) && pop);
`else
    assign coal = 1'b0;
`endif

    assign st_ready = ready_q && (fl_state == FL_IDLE) && ((count != FULL_CNT) || coal);
    assign accept   = st_valid && st_ready;
    assign alloc    = accept && !coal;
    assign merge    = accept && coal;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_we[i] = (alloc && (tail == PTR_W'(i))) || (merge && (young == PTR_W'(i)));
        sb_entry #(.WA_W(WA_W), .DATA_W(DATA_W)) u_ent (
            .clka     (clka),
            .we       (ent_we[i]),
            .waddr    (st_addr[ADDR_W-1:2]),
            .wdata    (st_data),
            .cmp_addr (ld_addr[ADDR_W-1:2]),
            .addr     (ent_addr[i]),
            .data     (ent_data[i]),
            .match    (ent_match[i])
        );
    end

    // Walk oldest to youngest so the last hit seen is the youngest.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && ent_match[head + PTR_W'(k)]) begin
                ld_hit  = 1'b1;
                ld_data = ent_data[head + PTR_W'(k)];
            end
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ready_q  <= 1'b0;
            fl_state <= FL_IDLE;
        end else begin
            ready_q  <= 1'b1;
            fl_state <= fl_next;
            if (alloc) tail <= tail + PTR_W'(1);
            if (pop)   head <= head + PTR_W'(1);
            if (alloc && !pop)      count <= count + CNT_W'(1);
            else if (!alloc && pop) count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        fl_next    = fl_state;
        flush_done = 1'b0;
        case (fl_state)
            FL_IDLE:  if (flush) fl_next = FL_DRAIN;
            FL_DRAIN: if ((count == '0) && !alloc) begin
                          flush_done = 1'b1;
                          fl_next    = FL_WAIT;
                      end
            FL_WAIT:  if (!flush) fl_next = FL_IDLE;
            default:  fl_next = FL_IDLE;
        endcase
    end

    assign mem_we    = (count != '0);
    assign mem_addr  = {ent_addr[head], 2'b00};
    assign mem_wdata = ent_data[head];
    assign sb_empty  = (count == '0);
    assign sb_count  = count;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, full stall, forwarding, wrap, flush and async reset.
module tb_store_buffer;
    logic        clka = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        flush;
    logic        flush_done;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clka(clka), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .flush(flush), .flush_done(flush_done), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0;
        mem_ack = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready got %0h want 0", st_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h want 1", sb_empty); end
        checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sb_count); end
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld got %0h/%0h want 0/0", ld_hit, ld_data); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %0h want 0", flush_done); end
        rst = 1'b1;
        tick();
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0h want 1", st_ready); end
    endtask

    task automatic test_basic_drain();
        mem_ack = 1'b1;
        st_valid = 1'b1; st_addr = 32'd80; st_data = 32'd5;
        tick();
        st_addr = 32'd84; st_data = 32'd7;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd80 || mem_wdata !== 32'd5) begin errors++; $display("FAIL drain_first got we=%0h %0d/%0d want 1 80/5", mem_we, mem_addr, mem_wdata); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd84 || mem_wdata !== 32'd7) begin errors++; $display("FAIL drain_second got we=%0h %0d/%0d want 1 84/7", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%0h we=%0h want 1 0", sb_empty, mem_we); end
    endtask

    task automatic test_full_stall();
        logic acc;
        logic [31:0] exp_a [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_addr = 32'(4 * k); st_data = 32'(32'h100 + 4 * k);
            tick();
        end
        st_addr = 32'd16; st_data = 32'h110;
        #1;
        checks++; if (sb_count !== 3'd4 || st_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt=%0d rdy=%0h want 4 0", sb_count, st_ready); end
        tick();
        checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_hold got cnt=%0d want 4", sb_count); end
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== exp_a[k] || mem_wdata !== 32'h100 + exp_a[k]) begin errors++; $display("FAIL full_order%0d got we=%0h %0h/%0h want 1 %0h/%0h", k, mem_we, mem_addr, mem_wdata, exp_a[k], 32'h100 + exp_a[k]); end
            acc = st_valid && st_ready;
            tick();
            if (acc) st_valid = 1'b0;
        end
        checks++; if (sb_empty !== 1'b1 || st_valid !== 1'b0) begin errors++; $display("FAIL full_end got empty=%0h pending=%0h want 1 0", sb_empty, st_valid); end
    endtask

    task automatic test_forwarding();
        mem_ack = 1'b0;
        st_valid = 1'b1; st_addr = 32'd84; st_data = 32'd7;
        tick();
        st_data = 32'd9;
        tick();
        st_valid = 1'b0; ld_addr = 32'd86;
        #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin errors++; $display("FAIL fwd_hit got %0h/%0d want 1/9", ld_hit, ld_data); end
        ld_addr = 32'd88;
        #1;
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin errors++; $display("FAIL fwd_miss got %0h/%0d want 0/0", ld_hit, ld_data); end
`ifdef SB_COALESCE_EN
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL fwd_count got %0d want 1", sb_count); end
        mem_ack = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'd84 || mem_wdata !== 32'd9) begin errors++; $display("FAIL fwd_drain0 got %0d/%0d want 84/9", mem_addr, mem_wdata); end
        tick();
`else
        checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL fwd_count got %0d want 2", sb_count); end
        mem_ack = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'd84 || mem_wdata !== 32'd7) begin errors++; $display("FAIL fwd_drain0 got %0d/%0d want 84/7", mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_addr !== 32'd84 || mem_wdata !== 32'd9) begin errors++; $display("FAIL fwd_drain1 got %0d/%0d want 84/9", mem_addr, mem_wdata); end
        tick();
`endif
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %0h want 1", sb_empty); end
        ld_addr = '0;
    endtask

    task automatic test_back_to_back();
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_addr = 32'(32'h100 + 4 * k); st_data = 32'(k + 1);
            tick();
        end
        st_addr = 32'h110; st_data = 32'd5; mem_ack = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0 || sb_count !== 3'd4) begin errors++; $display("FAIL b2b_full got rdy=%0h cnt=%0d want 0 4", st_ready, sb_count); end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (sb_count !== 3'd3 || st_ready !== 1'b1) begin errors++; $display("FAIL b2b_reject got cnt=%0d rdy=%0h want 3 1", sb_count, st_ready); end
        tick();
        st_valid = 1'b0;
        checks++; if (sb_count !== 3'd4 || mem_addr !== 32'h104) begin errors++; $display("FAIL b2b_accept got cnt=%0d head=%0h want 4 104", sb_count, mem_addr); end
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (mem_addr !== 32'(32'h104 + 4 * k) || mem_wdata !== 32'(k + 2)) begin errors++; $display("FAIL b2b_order%0d got %0h/%0d want %0h/%0d", k, mem_addr, mem_wdata, 32'h104 + 4 * k, k + 2); end
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            st_valid = 1'b1; st_addr = 32'(32'h200 + 4 * k); st_data = 32'(32'h50 + k);
            tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== 32'(32'h200 + 4 * k) || mem_wdata !== 32'(32'h50 + k)) begin errors++; $display("FAIL wrap%0d got we=%0h %0h/%0h want 1 %0h/%0h", k, mem_we, mem_addr, mem_wdata, 32'h200 + 4 * k, 32'h50 + k); end
        end
        st_valid = 1'b0;
        tick();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0h want 1", sb_empty); end
    endtask

    task automatic test_flush();
        int cnt, mst, pulses;
        logic exp_done;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_addr = 32'(32'h300 + 4 * k); st_data = 32'(32'hA0 + k);
            tick();
        end
        st_valid = 1'b0; flush = 1'b1;
        tick();
        cnt = 3; mst = 1; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            mem_ack = (i >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            exp_done = (mst == 1) && (cnt == 0);
            checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL flush_ready%0d got %0h want 0", i, st_ready); end
            checks++; if (flush_done !== exp_done) begin errors++; $display("FAIL flush_done%0d got %0h want %0h", i, flush_done, exp_done); end
            checks++; if (mem_we !== (cnt != 0)) begin errors++; $display("FAIL flush_we%0d got %0h want %0h", i, mem_we, cnt != 0); end
            if (flush_done === 1'b1) pulses++;
            if (cnt != 0 && mem_ack) cnt--;
            if (exp_done) mst = 2;
            @(posedge clka);
            #1;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses got %0d want 1", pulses); end
        flush = 1'b0; mem_ack = 1'b0;
        tick();
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL flush_release got %0h want 1", st_ready); end
    endtask

    task automatic test_async_reset();
        mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st_valid = 1'b1; st_addr = 32'(32'h400 + 4 * k); st_data = 32'(k + 1);
            tick();
        end
        st_valid = 1'b0; mem_ack = 1'b1;
        checks++; if (mem_we !== 1'b1 || sb_count !== 3'd2) begin errors++; $display("FAIL arst_pre got we=%0h cnt=%0d want 1 2", mem_we, sb_count); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || sb_count !== 3'd0 || sb_empty !== 1'b1 || st_ready !== 1'b0) begin errors++; $display("FAIL arst_now got we=%0h cnt=%0d empty=%0h rdy=%0h want 0 0 1 0", mem_we, sb_count, sb_empty, st_ready); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (mem_we !== 1'b0 || sb_count !== 3'd0) begin errors++; $display("FAIL arst_after%0d got we=%0h cnt=%0d want 0 0", k, mem_we, sb_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_full_stall();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline MEM stage and the data RAM; it is the downstream consumer of the CPU store outputs (memwrite/dataadr/writedata).
- Accepts word stores from the CPU without stalling while entries are free, and drains them in order to the data RAM.
- Forwards buffered data to loads that hit a pending store.
- Provides a flush handshake for fence/halt.

Parameters:
- DEPTH, 4, number of entries (power of 2, >=2).
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width.

Ports:
- clka  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset: 0 = reset.
- st_valid  in  1  CPU store request (MEM-stage memwrite).
- st_addr  in  ADDR_W  store byte address; bits [1:0] ignored.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer can accept; CPU stalls when 0.
- ld_addr  in  ADDR_W  MEM-stage load address.
- ld_hit  out  1  combinational: a valid entry matches ld_addr[ADDR_W-1:2].
- ld_data  out  DATA_W  combinational: data of the youngest matching entry; 0 when no hit.
- mem_we  out  1  write request to data RAM.
- mem_addr  out  ADDR_W  head entry address, bits [1:0] forced to 0.
- mem_wdata  out  DATA_W  head entry data.
- mem_ack  in  1  RAM accepted the head write this cycle.
- flush  in  1  level request to drain completely.
- flush_done  out  1  one-cycle pulse when a flush completes.
- sb_empty  out  1  no valid entries.
- sb_count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
Reset (rst=0, asynchronous, also mid-operation):
- Head/tail pointers, count and flush state are cleared; all entries are discarded and never written.
- Outputs: st_ready=0 while rst=0, then 1 from the first cycle after release. mem_we=0, flush_done=0, sb_empty=1, sb_count=0, ld_hit=0, ld_data=0.

Push and pop:
- Push: st_valid && st_ready at a clock edge. The entry is written at tail, tail = tail+1 mod DEPTH, count+1.
- Pop: mem_we && mem_ack at a clock edge. Head advances mod DEPTH, count-1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointer wrap DEPTH-1 -> 0 is seamless.

Drain:
- mem_we = !sb_empty, driven combinationally from registered state.
- mem_addr and mem_wdata hold stable until mem_ack.
- Latency: a push into an empty buffer gives mem_we=1 on the following cycle. There is no same-cycle bypass to RAM.

Full and ready:
- st_ready = (count < DEPTH) && (flush state == IDLE).
- When full, no push is accepted even if a pop happens in that cycle. This is a conservative stall.
- A store presented with st_ready=0 is ignored; the CPU must hold it.

Load forwarding:
- Compares ld_addr[ADDR_W-1:2] with every valid entry. The youngest match (closest to tail) wins.
- An entry being popped this cycle still counts as valid for forwarding.
- A store being pushed this cycle is not visible to forwarding until the next cycle.

Flush FSM:
- IDLE: flush=1 -> DRAIN.
- DRAIN: st_ready=0. When count==0 (no pending push): pulse flush_done for one cycle, go to WAIT.
- WAIT: stays until flush=0, then -> IDLE.
- flush asserted while already empty: DRAIN -> pulse on the next cycle.

Optional Feature:
- Macro: SB_COALESCE_EN.
- Defined: a pushed store whose word address equals the youngest valid entry's word address overwrites that entry's data. No allocation, count unchanged, st_ready is unaffected by fullness for that store.
- Coalescing is suppressed, and a new entry allocated, when the youngest entry is also the head and is being popped (mem_we && mem_ack) in the same cycle.
- Not defined: every accepted store allocates its own entry. Logic is identical otherwise.

Test Plan:
1. Reset then stores (80,5), (84,7) with mem_ack tied 1 -> RAM sees addr 80 data 5, then addr 84 data 7 on consecutive cycles, in order; sb_empty=1 after.
2. mem_ack=0, four stores to 0,4,8,12 -> sb_count=4, st_ready=0; fifth store held; raise mem_ack -> writes emerge in order 0,4,8,12, then the fifth.
3. Stores (84,7) then (84,9) pending, ld_addr=86 -> ld_hit=1, ld_data=9. ld_addr=88 -> ld_hit=0, ld_data=0. With SB_COALESCE_EN: sb_count=1 and RAM sees only (84,9).
4. Full buffer with push and pop in the same cycle -> push rejected, count 4->3; next cycle push accepted. Pointer wrap verified over 10 stores.
5. Three entries pending, flush=1, mem_ack random -> st_ready=0 throughout; flush_done pulses once exactly one cycle after the last pop; st_ready returns to 1 after flush drops.
6. Assert rst=0 asynchronously mid-drain with 2 entries -> mem_we drops immediately, sb_count=0; no further RAM writes after release.
